dram_ctrl: RTL
==============

DRAM_CTRL -- requirements
Module: dram_ctrl

Interface
REQ-001 SHALL have parameter T_RP, default 5, precharge-to-activate wait in cycles (legal 1..15).
REQ-002 SHALL have parameter T_RCD, default 5, activate-to-column wait in cycles (legal 1..15).
REQ-003 SHALL have parameter T_CL, default 5, write column-to-done wait in cycles (legal 1..15).
REQ-004 SHALL have port ACLK, input, 1, sole clock; all state updates on its rising edge.
REQ-005 SHALL have port ARESET, input, 1, asynchronous active-high reset.
REQ-006 SHALL have port req_valid, input, 1, access request valid.
REQ-007 SHALL have port req_ready, output, 1, controller can accept a request.
REQ-008 SHALL have port req_write, input, 1, 1 = write, 0 = read.
REQ-009 SHALL have port req_addr, input, 21, word address: [20:10] row, [9:0] column.
REQ-010 SHALL have ports req_wdata, input, 32, and req_wstrb, input, 4, write data and active-high byte strobes.
REQ-011 SHALL have ports rsp_valid, output, 1, and rsp_rdata, output, 32, one-cycle read-data pulse plus data.
REQ-012 SHALL have port wr_done, output, 1, one-cycle write-complete pulse.
REQ-013 SHALL have DRAM pins CSn, RASn, CASn, output, 1 each, active-low; WEn, output, 4, active-low byte write enables; A, output, 11, row/column address; D, output, 32, write data.
REQ-014 SHALL have DRAM inputs Q, input, 32, read data, and DRAM_VALID, input, 1, Q valid.

Function
REQ-015 FSM states SHALL be IDLE, PRE, ACT, COL, WAIT.
REQ-016 req_ready SHALL be 1 only in IDLE; handshake = req_valid & req_ready; the controller SHALL latch write, address, wdata and wstrb at the handshake.
REQ-017 At handshake: open row equal to request row -> COL; row open and different -> PRE; no row open -> ACT.
REQ-018 PRE SHALL last T_RP cycles, with CSn=0, RASn=0, CASn=1, WEn=4'h0 in the first cycle only and NOP thereafter; then ACT.
REQ-019 ACT SHALL last T_RCD cycles, with CSn=0, RASn=0, CASn=1, WEn=4'hF, A=row in the first cycle only; on exit the row is recorded as open.
REQ-020 COL SHALL last 1 cycle with CSn=0, RASn=1, CASn=0, A={1'b0,col}. Read: WEn=4'hF. Write: WEn=~wstrb, D=wdata. Then WAIT.
REQ-021 NOP SHALL be CSn=0, RASn=1, CASn=1, WEn=4'hF; IDLE SHALL drive CSn=1, other pins high or 0 as in reset.
REQ-022 Write WAIT SHALL last T_CL cycles; wr_done=1 in the last WAIT cycle; next state IDLE.
REQ-023 Read WAIT SHALL hold until DRAM_VALID=1. The controller SHALL then capture Q into rsp_rdata, assert rsp_valid in the next cycle for exactly one cycle, and enter IDLE in that same cycle.
REQ-024 DRAM_VALID outside a read WAIT SHALL be ignored.
REQ-025 wstrb=4'h0 writes SHALL still perform the full sequence with WEn=4'hF.
REQ-026 The open-row policy SHALL hold: the row stays open until a miss forces PRE.
REQ-027 Wait counters SHALL be 4 bits, load parameter-1 on state entry, and decrement to 0 (no wrap).

Reset
REQ-028 On ARESET the block SHALL go to IDLE and clear the row-open flag and counters. Outputs: req_ready=0 while ARESET high, then 1; rsp_valid=0; wr_done=0; rsp_rdata=0; CSn=1; RASn=1; CASn=1; WEn=4'hF; A=0; D=0.
REQ-029 Reset mid-operation SHALL abort the access with no rsp_valid or wr_done; the next access SHALL take the no-row-open path (ACT).

Structure
REQ-030 Package dram_ctrl_pkg SHALL hold the state enum, the command encodings (PRE/ACT/RD/WR/NOP) and the row/column width constants.
REQ-031 One sub-module, dram_timer (loadable 4-bit down-counter with a done flag), SHALL be instantiated once and shared across PRE/ACT/WAIT.

Verification (defaults T_RP=T_RCD=T_CL=5; handshake at cycle N)
REQ-032 First write after reset, addr 0x00C04 (row 3, col 4), wdata 0xDEADBEEF, wstrb 4'hF: ACT at N+1, A=3; COL at N+6, A=4, WEn=0; wr_done at N+11; req_ready at N+12.
REQ-033 Read hit, row 3 col 4, model DRAM_VALID at N+6 with Q=0xDEADBEEF: no PRE/ACT; COL at N+1; rsp_valid=1, rsp_rdata=0xDEADBEEF at N+7.
REQ-034 Read miss to row 7 while row 3 is open: PRE at N+1, ACT at N+6 with A=7, COL at N+11.
REQ-035 Write with wstrb 4'b0101: WEn=4'b1010 during COL only.
REQ-036 ARESET pulse during ACT: CSn=1 and state IDLE immediately; no wr_done; next request issues ACT, not PRE.
REQ-037 req_valid held high during an access: exactly one acceptance per IDLE visit; spurious DRAM_VALID in IDLE produces no rsp_valid.

Source files
------------

// File: rtl/dram_ctrl_pkg.sv
// Shared types and constants for the single-bank DRAM controller:
// FSM states, DRAM command pin encodings and address field widths.
package dram_ctrl_pkg;

  localparam int ROW_W  = 11;
  localparam int COL_W  = 10;
  localparam int ADDR_W = ROW_W + COL_W;

  typedef enum logic [2:0] {
    S_IDLE,
    S_PRE,
    S_ACT,
    S_COL,
    S_WAIT
  } state_t;

  typedef struct packed {
    logic       csn;
    logic       rasn;
    logic       casn;
    logic [3:0] wen;
  } cmd_t;

  localparam cmd_t CMD_IDLE = '{1'b1, 1'b1, 1'b1, 4'hF};
  localparam cmd_t CMD_NOP  = '{1'b0, 1'b1, 1'b1, 4'hF};
  localparam cmd_t CMD_PRE  = '{1'b0, 1'b0, 1'b1, 4'h0};
  localparam cmd_t CMD_ACT  = '{1'b0, 1'b0, 1'b1, 4'hF};
  localparam cmd_t CMD_RD   = '{1'b0, 1'b1, 1'b0, 4'hF};
  localparam cmd_t CMD_WR   = '{1'b0, 1'b1, 1'b0, 4'h0};

  // Column command; writes carry the inverted byte strobes on WEn.
  function automatic cmd_t col_cmd(input logic wr, input logic [3:0] wstrb);
    cmd_t c;
    c = wr ? CMD_WR : CMD_RD;
    if (wr) c.wen = ~wstrb;
    return c;
  endfunction

endpackage

// File: rtl/dram_ctrl_timer.sv
// Loadable 4-bit down-counter that saturates at zero; done flags the zero count.
module dram_timer (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       load_i,
  input  logic [3:0] load_val_i,
  output logic [3:0] cnt_o,
  output logic       done_o
);

  logic [3:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i)              cnt_d = load_val_i;
    else if (cnt_q != 4'd0)  cnt_d = cnt_q - 4'd1;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

  assign cnt_o  = cnt_q;
  assign done_o = (cnt_q == 4'd0);

endmodule

// File: rtl/dram_ctrl.sv
// Single-bank DRAM controller with an open-row policy. All DRAM pins are
// registered; one shared timer paces PRE, ACT and the write WAIT.
module dram_ctrl
  import dram_ctrl_pkg::*;
#(
  parameter int T_RP  = 5,
  parameter int T_RCD = 5,
  parameter int T_CL  = 5
) (
  input  logic              ACLK,
  input  logic              ARESET,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  input  logic [3:0]        req_wstrb,
  output logic              rsp_valid,
  output logic [31:0]       rsp_rdata,
  output logic              wr_done,
  output logic              CSn,
  output logic              RASn,
  output logic              CASn,
  output logic [3:0]        WEn,
  output logic [ROW_W-1:0]  A,
  output logic [31:0]       D,
  input  logic [31:0]       Q,
  input  logic              DRAM_VALID
);

  localparam logic [3:0] RP_LD  = 4'(T_RP  - 1);
  localparam logic [3:0] RCD_LD = 4'(T_RCD - 1);
  localparam logic [3:0] CL_LD  = 4'(T_CL  - 1);

  state_t             state_q;
  logic               row_open_q;
  logic [ROW_W-1:0]   open_row_q;
  logic               wr_q;
  logic [ROW_W-1:0]   row_q;
  logic [COL_W-1:0]   col_q;
  logic [31:0]        wdata_q;
  logic [3:0]         wstrb_q;
  cmd_t               cmd_q;
  logic [ROW_W-1:0]   a_q;
  logic [31:0]        d_q;
  logic               rsp_valid_q;
  logic [31:0]        rsp_rdata_q;
  logic               wr_done_q;

  logic               hs, hit;
  logic [ROW_W-1:0]   req_row;
  logic               tmr_load, tmr_done;
  logic [3:0]         tmr_val, tmr_cnt;

  assign req_ready = (state_q == S_IDLE) && !ARESET;
  assign hs        = req_valid && req_ready;
  assign req_row   = req_addr[ADDR_W-1:COL_W];
  assign hit       = row_open_q && (req_row == open_row_q);

  // Timer loads coincide with entry into PRE, ACT or write WAIT.
  always_comb begin
    tmr_load = 1'b0;
    tmr_val  = '0;
    unique case (state_q)
      S_IDLE: if (hs && !hit) begin
        tmr_load = 1'b1;
        tmr_val  = row_open_q ? RP_LD : RCD_LD;
      end
      S_PRE: if (tmr_done) begin
        tmr_load = 1'b1;
        tmr_val  = RCD_LD;
      end
      S_COL: if (wr_q) begin
        tmr_load = 1'b1;
        tmr_val  = CL_LD;
      end
      default: ;
    endcase
  end

  dram_timer u_timer (
    .clk_i      (ACLK),
    .rst_i      (ARESET),
    .load_i     (tmr_load),
    .load_val_i (tmr_val),
    .cnt_o      (tmr_cnt),
    .done_o     (tmr_done)
  );

  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      state_q     <= S_IDLE;
      row_open_q  <= 1'b0;
      open_row_q  <= '0;
      wr_q        <= 1'b0;
      row_q       <= '0;
      col_q       <= '0;
      wdata_q     <= '0;
      wstrb_q     <= '0;
      cmd_q       <= CMD_IDLE;
      a_q         <= '0;
      d_q         <= '0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      wr_done_q   <= 1'b0;
    end else begin
      rsp_valid_q <= 1'b0;
      wr_done_q   <= 1'b0;
      unique case (state_q)
        S_IDLE: begin
          cmd_q <= CMD_IDLE;
          a_q   <= '0;
          d_q   <= '0;
          if (hs) begin
            wr_q    <= req_write;
            row_q   <= req_row;
            col_q   <= req_addr[COL_W-1:0];
            wdata_q <= req_wdata;
            wstrb_q <= req_wstrb;
            if (hit) begin
              state_q <= S_COL;
              cmd_q   <= col_cmd(req_write, req_wstrb);
              a_q     <= {1'b0, req_addr[COL_W-1:0]};
              d_q     <= req_write ? req_wdata : '0;
            end else if (row_open_q) begin
              state_q    <= S_PRE;
              cmd_q      <= CMD_PRE;
              row_open_q <= 1'b0;
            end else begin
              state_q <= S_ACT;
              cmd_q   <= CMD_ACT;
              a_q     <= req_row;
            end
          end
        end
        S_PRE: begin
          cmd_q <= CMD_NOP;
          if (tmr_done) begin
            state_q <= S_ACT;
            cmd_q   <= CMD_ACT;
            a_q     <= row_q;
          end
        end
        S_ACT: begin
          cmd_q <= CMD_NOP;
          if (tmr_done) begin
            state_q    <= S_COL;
            cmd_q      <= col_cmd(wr_q, wstrb_q);
            a_q        <= {1'b0, col_q};
            d_q        <= wr_q ? wdata_q : '0;
            row_open_q <= 1'b1;
            open_row_q <= row_q;
          end
        end
        S_COL: begin
          state_q <= S_WAIT;
          cmd_q   <= CMD_NOP;
          // wr_done is registered, so it is raised one cycle ahead of the last WAIT cycle.
          if (wr_q && CL_LD == 4'd0) wr_done_q <= 1'b1;
        end
        S_WAIT: begin
          cmd_q <= CMD_NOP;
          if (wr_q) begin
            if (tmr_cnt == 4'd1) wr_done_q <= 1'b1;
            if (tmr_done) begin
              state_q <= S_IDLE;
              cmd_q   <= CMD_IDLE;
              a_q     <= '0;
              d_q     <= '0;
            end
          end else if (DRAM_VALID) begin
            rsp_rdata_q <= Q;
            rsp_valid_q <= 1'b1;
            state_q     <= S_IDLE;
            cmd_q       <= CMD_IDLE;
            a_q         <= '0;
            d_q         <= '0;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign CSn       = cmd_q.csn;
  assign RASn      = cmd_q.rasn;
  assign CASn      = cmd_q.casn;
  assign WEn       = cmd_q.wen;
  assign A         = a_q;
  assign D         = d_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;
  assign wr_done   = wr_done_q;

endmodule
